// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared widths, reset level and discard-state encodings for the MEM/WB stage
package mem_wb_stage_pkg;

    localparam int MM_TO_NEXT_W = 128;
    localparam int WB_DATA_W    = 32;
    localparam logic RST_ENABLE = 1'b0;

    localparam logic [1:0] DROP0 = 2'd0;
    localparam logic [1:0] DROP1 = 2'd1;
    localparam logic [1:0] DROP2 = 2'd2;

    // Never more than two orphaned requests can be in flight, so clamp at DROP2.
    function automatic logic [1:0] drop_next(input logic [1:0] cnt,
                                             input logic [1:0] inc,
                                             input logic       dec);
        logic [2:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc} - {2'b00, dec};
        if (sum > {1'b0, DROP2}) begin
            return DROP2;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/mem_resp_drop_fsm.sv
// rtl/mem_resp_drop_fsm.sv - counts data-memory responses still owed to requests killed by a flush
module mem_resp_drop_fsm
    import mem_wb_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_orphan_i,
    input  logic       excep_flush_i,
    input  logic       mem_orphan_i,
    input  logic       data_ok_i,
    output logic [1:0] drop_cnt_o
);

    logic [1:0] r_drop_cnt;
    logic [1:0] w_inc;
    logic       w_dec;

    always_comb begin
        w_inc = 2'd0;
        if (excep_flush_i) begin
            w_inc = {1'b0, ex_orphan_i} + {1'b0, mem_orphan_i};
        end
        w_dec = data_ok_i & (r_drop_cnt != DROP0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            r_drop_cnt <= DROP0;
        end else begin
            r_drop_cnt <= drop_next(r_drop_cnt, w_inc, w_dec);
        end
    end

    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM-stage response wait/buffer/discard control plus MEM/WB pipeline register
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int BUS_W  = MM_TO_NEXT_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line1_pre_valid_i,
    input  logic              line2_pre_valid_i,
    input  logic [BUS_W-1:0]  pre_bus_i,
    input  logic              mem_req_i,
    input  logic              ex_orphan_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              wb_allowin_i,
    input  logic              excep_flush_i,
    output logic              now_allowin_o,
    output logic              line1_wb_valid_o,
    output logic              line2_wb_valid_o,
    output logic [BUS_W-1:0]  wb_bus_o,
    output logic [DATA_W-1:0] wb_rdata_o,
    output logic [1:0]        drop_cnt_o
);

    logic              r_buf_valid;
    logic [DATA_W-1:0] r_buf_data;
    logic              r_line1_wb_valid;
    logic              r_line2_wb_valid;
    logic [BUS_W-1:0]  r_wb_bus;
    logic [DATA_W-1:0] r_wb_rdata;

    logic [1:0]        w_drop_cnt;
    logic              w_mem_valid;
    logic              w_resp_take;
    logic              w_resp_got;
    logic              w_now_ready;
    logic              w_mem_orphan;

    assign w_mem_valid  = line1_pre_valid_i | line2_pre_valid_i;
    // A response only belongs to the MEM group once every orphaned one has drained.
    assign w_resp_take  = data_ok_i & (w_drop_cnt == DROP0);
    assign w_resp_got   = w_resp_take | r_buf_valid;
    assign w_now_ready  = ~mem_req_i | w_resp_got;
    assign w_mem_orphan = w_mem_valid & mem_req_i & ~w_resp_got;

    assign now_allowin_o = ~w_mem_valid | (w_now_ready & wb_allowin_i);

    mem_resp_drop_fsm u_drop_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_orphan_i   (ex_orphan_i),
        .excep_flush_i (excep_flush_i),
        .mem_orphan_i  (w_mem_orphan),
        .data_ok_i     (data_ok_i),
        .drop_cnt_o    (w_drop_cnt)
    );

    // Holds a response that arrived while WB refused the group; buf_valid implies ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (excep_flush_i || wb_allowin_i) begin
            r_buf_valid <= 1'b0;
        end else if (w_resp_take && w_mem_valid && mem_req_i) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            r_line1_wb_valid <= 1'b0;
            r_line2_wb_valid <= 1'b0;
            r_wb_bus         <= '0;
            r_wb_rdata       <= '0;
        end else begin
            if (excep_flush_i) begin
                r_line1_wb_valid <= 1'b0;
                r_line2_wb_valid <= 1'b0;
            end else if (wb_allowin_i) begin
                r_line1_wb_valid <= line1_pre_valid_i & w_now_ready;
                r_line2_wb_valid <= line2_pre_valid_i & w_now_ready;
            end
            if (wb_allowin_i && w_mem_valid && w_now_ready) begin
                r_wb_bus   <= pre_bus_i;
                r_wb_rdata <= r_buf_valid ? r_buf_data : rdata_i;
            end
        end
    end

    assign line1_wb_valid_o = r_line1_wb_valid;
    assign line2_wb_valid_o = r_line2_wb_valid;
    assign wb_bus_o         = r_wb_bus;
    assign wb_rdata_o       = r_wb_rdata;
    assign drop_cnt_o       = w_drop_cnt;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM-stage control plus MEM/WB pipeline register for the dual-issue pipeline; consumes the EX/MEM register outputs and the data-memory response channel. It holds the MEM group until its load/store response arrives, buffers a response that arrives while WB is stalled, and discards responses belonging to requests orphaned by an exception flush. Outputs feed the WB stage and the register-file write path.

## Interface
- BUS_W, 128: width of the MEM-to-WB payload bus, passed through unchanged
- DATA_W, 32: data-memory read data width
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- line1_pre_valid_i  in  1  line-1 valid from the EX/MEM register
- line2_pre_valid_i  in  1  line-2 valid from the EX/MEM register
- pre_bus_i  in  BUS_W  MEM-stage payload
- mem_req_i  in  1  current MEM group has an issued data-memory request awaiting response
- ex_orphan_i  in  1  EX has an issued request that the current flush kills
- data_ok_i  in  1  data-memory response strobe, one per request, in order
- rdata_i  in  DATA_W  response data, qualified by data_ok_i
- wb_allowin_i  in  1  WB stage accepts a new group this cycle
- excep_flush_i  in  1  exception flush, kills MEM and WB contents
- now_allowin_o  out  1  MEM stage accepts a new group (to EX/MEM)
- line1_wb_valid_o  out  1  registered line-1 valid into WB
- line2_wb_valid_o  out  1  registered line-2 valid into WB
- wb_bus_o  out  BUS_W  registered payload
- wb_rdata_o  out  DATA_W  registered load data
- drop_cnt_o  out  2  pending-discard count (debug/verification)

## Operation
- mem_valid = line1_pre_valid_i | line2_pre_valid_i.
- resp_take = data_ok_i & (drop_cnt == 0): response belongs to the MEM group.
- resp_got = resp_take | buf_valid.
- now_ready = ~mem_req_i | resp_got.
- now_allowin_o = ~mem_valid | (now_ready & wb_allowin_i).
- Response buffer (buf_valid, buf_data[DATA_W-1:0]): set with rdata_i when resp_take & mem_valid & mem_req_i & ~wb_allowin_i; cleared when the group transfers to WB or on excep_flush_i. resp_take while not transferring and buf_valid already 1 is illegal (one response per request).
- Discard FSM (drop_cnt), states DROP0/DROP1/DROP2: inc = ex_orphan_i + (excep_flush_i & mem_valid & mem_req_i & ~resp_got) on flush cycles, else 0; dec = data_ok_i & (drop_cnt != 0). next = drop_cnt + inc - dec, saturate at 2. A response arriving in the flush cycle with drop_cnt==0 is consumed by the MEM group (no orphan counted for it).
- MEM/WB register, on wb_allowin_i: lineN_wb_valid <= lineN_pre_valid_i & now_ready & ~excep_flush_i; wb_bus_o <= pre_bus_i and wb_rdata_o <= (buf_valid ? buf_data : rdata_i) when mem_valid & now_ready. Otherwise all hold.
- excep_flush_i clears both wb valids and buf_valid regardless of wb_allowin_i.

## Timing
- Reset: all outputs 0, drop_cnt = DROP0, buf_valid = 0, buf_data = 0; now_allowin_o = 1 after reset (mem_valid 0).
- now_allowin_o is combinational from data_ok_i, wb_allowin_i, valids, buffer state.
- Latency: group with response in cycle N appears at WB outputs in N+1 if wb_allowin_i in N; buffered data appears the cycle after wb_allowin_i rises.
- Discarded responses never reach the buffer or wb_rdata_o and never raise now_ready.
- Reset asserted mid-operation clears everything immediately; in-flight responses after reset are the memory side's responsibility.

## Structure
- Bus widths (MmToNext, WB bus) and RstEnable from the shared define header; drop-state encodings DROP0=2'd0, DROP1=2'd1, DROP2=2'd2 in the shared package.
- One natural sub-module: mem_resp_drop_fsm (drop_cnt counter/FSM); buffer and register stay inline.

## Test plan
- Non-memory group (mem_req_i=0), wb_allowin_i=1, pre_bus_i=0xA5.. -> now_allowin_o=1, wb valids set and bus=0xA5.. next cycle.
- Load, data_ok_i with rdata_i=0x12345678 two cycles after entering MEM -> now_allowin_o 0 until response, wb_rdata_o=0x12345678 one cycle later.
- Load response 0xDEADBEEF while wb_allowin_i=0 for 3 cycles -> buf_valid=1, stage holds, rdata_i changes ignored, wb_rdata_o=0xDEADBEEF the cycle after wb_allowin_i=1.
- Flush with MEM load outstanding and ex_orphan_i=1 -> drop_cnt=2; next two data_ok_i pulses (0x1111, 0x2222) dropped, drop_cnt 2->1->0; third response 0x3333 consumed by new load.
- Flush in same cycle as data_ok_i, drop_cnt=0, ex_orphan_i=0 -> drop_cnt stays 0, wb valids 0, buffer clear.
- rst_n pulled low with drop_cnt=1 and buf_valid=1 -> all outputs and state 0 immediately, now_allowin_o=1.
